mod_reduce_pipe: RTL and testbench



---
 rtl/mod_reduce_pipe.sv | 174 +++++++++++++++++
 tb/tb_mod_reduce_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mod_reduce_pipe.sv
// rtl/mod_reduce_pipe.sv - pipelined R = X mod M (X < 2M) via skewed chunked borrow-chain subtract and final select
// Optional macro REDUCE_REG_OUT_EN adds one output register stage (latency NCHUNK+2 instead of NCHUNK+1).
module mod_reduce_pipe #(
  parameter int IN_WIDTH    = 501,
  parameter int CHUNK_WIDTH = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  input  logic [IN_WIDTH-1:0] S_in,
  input  logic                Cout_in,
  input  logic [IN_WIDTH-1:0] M,
  output logic [IN_WIDTH-1:0] R,
  output logic                reduced,
  output logic                out_valid
);

  localparam int CW     = CHUNK_WIDTH;
  localparam int NCHUNK = (IN_WIDTH + CW) / CW;
  localparam int XW     = NCHUNK * CW;

  logic [XW-1:0]       w_x_pad;
  logic [XW-1:0]       w_m_pad;
  logic [XW-1:0]       r_x_in;
  logic [XW-1:0]       r_m_in;
  logic                r_v_in;
  logic [NCHUNK-1:0]   r_vc;
  logic [IN_WIDTH-1:0] r_xc [NCHUNK];
  logic [NCHUNK:0]     w_bchain;
  logic [XW-1:0]       w_dal;
  logic                w_borrow;
  logic                w_unused_hi;
  logic [IN_WIDTH-1:0] r_sel_r;
  logic                r_sel_red;
  logic                r_sel_v;

  always_comb begin
    w_x_pad               = '0;
    w_x_pad[IN_WIDTH:0]   = {Cout_in, S_in};
    w_m_pad               = '0;
    w_m_pad[IN_WIDTH-1:0] = M;
  end

  always_ff @(posedge clk) begin
    r_x_in <= w_x_pad;
    r_m_in <= w_m_pad;
    if (!resetn) begin
      r_v_in <= 1'b0;
    end else begin
      r_v_in <= in_valid;
    end
  end

  // Valid travels alongside the slowest chunk; only this chain gates the outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_vc <= '0;
    end else begin
      r_vc <= {r_vc[NCHUNK-2:0], r_v_in};
    end
  end

  always_ff @(posedge clk) begin
    r_xc[0] <= r_x_in[IN_WIDTH-1:0];
    for (int i = 1; i < NCHUNK; i++) begin
      r_xc[i] <= r_xc[i-1];
    end
  end

  assign w_bchain[0] = 1'b0;

  genvar k;
  generate
    for (k = 0; k < NCHUNK; k++) begin : g_chunk
      localparam int DK = NCHUNK - 1 - k;
      logic [CW-1:0] w_xk;
      logic [CW-1:0] w_mk;
      logic [CW:0]   w_sub;
      logic [CW-1:0] r_d;
      logic          r_b;

      if (k == 0) begin : g_noskew
        assign w_xk = r_x_in[0 +: CW];
        assign w_mk = r_m_in[0 +: CW];
      end else begin : g_skew
        logic [CW-1:0] r_xs [k];
        logic [CW-1:0] r_ms [k];
        always_ff @(posedge clk) begin
          r_xs[0] <= r_x_in[k*CW +: CW];
          r_ms[0] <= r_m_in[k*CW +: CW];
          for (int j = 1; j < k; j++) begin
            r_xs[j] <= r_xs[j-1];
            r_ms[j] <= r_ms[j-1];
          end
        end
        assign w_xk = r_xs[k-1];
        assign w_mk = r_ms[k-1];
      end

      // Borrow-in comes from the previous chunk of the same operand, registered one cycle earlier.
      assign w_sub = {1'b0, w_xk} - {1'b0, w_mk} - {{CW{1'b0}}, w_bchain[k]};

      always_ff @(posedge clk) begin
        r_d <= w_sub[CW-1:0];
        r_b <= w_sub[CW];
      end

      assign w_bchain[k+1] = r_b;

      if (DK == 0) begin : g_nodeskew
        assign w_dal[k*CW +: CW] = r_d;
      end else begin : g_deskew
        logic [CW-1:0] r_ds [DK];
        always_ff @(posedge clk) begin
          r_ds[0] <= r_d;
          for (int j = 1; j < DK; j++) begin
            r_ds[j] <= r_ds[j-1];
          end
        end
        assign w_dal[k*CW +: CW] = r_ds[DK-1];
      end
    end
  endgenerate

  assign w_borrow    = w_bchain[NCHUNK];
  assign w_unused_hi = ^w_dal[XW-1:IN_WIDTH];

  // Final borrow clear means X >= M, so the difference is the reduced value.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sel_v   <= 1'b0;
      r_sel_r   <= '0;
      r_sel_red <= 1'b0;
    end else begin
      r_sel_v <= r_vc[NCHUNK-1];
      if (r_vc[NCHUNK-1]) begin
        if (w_borrow) begin
          r_sel_r   <= r_xc[NCHUNK-1];
          r_sel_red <= 1'b0;
        end else begin
          r_sel_r   <= w_dal[IN_WIDTH-1:0];
          r_sel_red <= 1'b1;
        end
      end
    end
  end

`ifdef REDUCE_REG_OUT_EN
  logic [IN_WIDTH-1:0] r_out_r;
  logic                r_out_red;
  logic                r_out_v;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_out_v   <= 1'b0;
      r_out_r   <= '0;
      r_out_red <= 1'b0;
    end else begin
      r_out_v   <= r_sel_v;
      r_out_r   <= r_sel_r;
      r_out_red <= r_sel_red;
    end
  end

  assign R         = r_out_r;
  assign reduced   = r_out_red;
  assign out_valid = r_out_v;
`else
  assign R         = r_sel_r;
  assign reduced   = r_sel_red;
  assign out_valid = r_sel_v;
`endif

endmodule

// File: tb/tb_mod_reduce_pipe.sv
// tb/tb_mod_reduce_pipe.sv - scoreboard bench for mod_reduce_pipe (honours REDUCE_REG_OUT_EN)
module tb_mod_reduce_pipe;

`ifdef REDUCE_REG_OUT_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  logic         in_valid;
  logic [500:0] S_in;
  logic         Cout_in;
  logic [500:0] M;
  logic [500:0] R;
  logic         reduced;
  logic         out_valid;

  typedef struct {
    logic [500:0] r;
    logic         red;
    int           issue;
  } exp_t;

  exp_t         sb[$];
  int           n_chk = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic         rst_at_edge = 1'b0;
  logic [500:0] last_r = '0;
  logic         last_red = 1'b0;

  mod_reduce_pipe dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .S_in     (S_in),
    .Cout_in  (Cout_in),
    .M        (M),
    .R        (R),
    .reduced  (reduced),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= resetn;
  end

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (!rst_at_edge) begin
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_R", R, 0);
        check_eq("rst_reduced", reduced, 0);
        last_r   = '0;
        last_red = 1'b0;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out_valid", out_valid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("latency", cyc - e.issue, LAT);
          check_eq("R", R, e.r);
          check_eq("reduced", reduced, e.red);
          last_r   = e.r;
          last_red = e.red;
        end
      end else begin
        check_eq("hold_R", R, last_r);
        check_eq("hold_reduced", reduced, last_red);
      end
    end
  end

  function automatic logic [501:0] rnd502();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v[501:0];
  endfunction

  task automatic drive(input logic v, input logic [501:0] x, input logic [500:0] m,
                       input logic [500:0] er, input logic ered);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid          = v;
    {Cout_in, S_in}   = x;
    M                 = m;
    if (v && resetn) begin
      e.r     = er;
      e.red   = ered;
      e.issue = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    logic [501:0] t;
    logic [501:0] u;
    t = rnd502();
    u = rnd502();
    drive(1'b0, t, u[500:0], '0, 1'b0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) idle();
    check_eq("drain_timeout", sb.size(), 0);
  endtask

  task automatic send_rand();
    logic [501:0] t;
    logic [501:0] x;
    logic [501:0] rr;
    logic [500:0] m;
    t = rnd502();
    m = t[500:0];
    if ($urandom_range(0, 3) == 0) m = m >> $urandom_range(1, 480);
    if (m == '0) m = 501'd1;
    t  = rnd502();
    x  = t % {m, 1'b0};
    rr = x % {1'b0, m};
    drive(1'b1, x, m, rr[500:0], x >= {1'b0, m});
  endtask

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    S_in     = '0;
    Cout_in  = 1'b0;
    M        = '0;
    repeat (10) @(posedge clk);
    #1;
    resetn = 1'b1;

    drive(1'b1, 502'd5, 501'd3, 501'd2, 1'b1);
    wait_drain();
    drive(1'b1, 502'd2, 501'd3, 501'd2, 1'b0);
    wait_drain();

    drive(1'b1, 502'd1 << 32, 501'd1, 501'hFFFF_FFFF, 1'b1);
    drive(1'b1, 502'd1 << 501, (501'd1 << 500) + 501'd1, (501'd1 << 500) - 501'd1, 1'b1);
    drive(1'b1, {1'b0, {501{1'b1}}}, {501{1'b1}}, 501'd0, 1'b1);
    drive(1'b1, {(501'd1 << 500) + 501'd7, 1'b0} - 502'd1, (501'd1 << 500) + 501'd7,
          (501'd1 << 500) + 501'd6, 1'b1);
    drive(1'b1, {1'b0, 501'h1234_5678_9abc_def0}, 501'd0, 501'h1234_5678_9abc_def0, 1'b1);
    drive(1'b1, {1'b1, 501'hdead_beef}, 501'd0, 501'hdead_beef, 1'b1);
    drive(1'b1, 502'd999, 501'd1000, 501'd999, 1'b0);
    drive(1'b1, 502'd1000, 501'd1000, 501'd0, 1'b1);
    drive(1'b1, {502{1'b1}}, 501'd1, {{500{1'b1}}, 1'b0}, 1'b1);
    wait_drain();

    for (int i = 0; i < 60; i++) send_rand();
    wait_drain();

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) idle();
      send_rand();
    end
    wait_drain();

    for (int i = 0; i < 10; i++) send_rand();
    @(posedge clk);
    #1;
    resetn   = 1'b0;
    in_valid = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    resetn   = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 25; i++) idle();
    drive(1'b1, 502'd7, 501'd4, 501'd3, 1'b1);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
